// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: segment codes (active-low, gfedcba)
// and the display FSM encoding.
package seg_scan_pkg;

  localparam int DIGITS_DEFAULT = 4;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } state_t;

endpackage

// File: rtl/seg_scan_driver_hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment code (gfedcba), zero latency.
module hex_to_seg7
  import seg_scan_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexes a hex value onto a common-anode display, stepping digits on scan_clk rising edges.
// Outputs lag digit_idx by one cycle; load is held off (ready=0) until the pending value commits at a frame wrap.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int DIGITS      = DIGITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  scan_clk,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic                  load,
  output logic                  ready,
  input  logic [DIGITS-1:0]     blank_mask,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   step;
  logic                   wrap;
  logic                   commit;

  logic [IDX_W-1:0]       digit_idx;
  logic [4*DIGITS-1:0]    disp_val;
  logic [4*DIGITS-1:0]    pending_val;
  logic                   pending_flag;

  state_t                 state_q;
  state_t                 state_d;
  logic [DIGITS-1:0]      an_d;
  logic [6:0]             seg_d;
  logic [6:0]             seg_code;
  logic [3:0]             cur_nibble;

  assign step   = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign wrap   = step && (digit_idx == IDX_W'(DIGITS - 1));
  assign commit = wrap && pending_flag;
  assign dp     = 1'b1;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], scan_clk};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      digit_idx <= '0;
    end else if (step) begin
      digit_idx <= wrap ? '0 : digit_idx + IDX_W'(1);
    end
  end

  // pending_flag=1 implies ready=0, so commit and capture can never collide.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      disp_val     <= '0;
      pending_val  <= '0;
      pending_flag <= 1'b0;
      ready        <= 1'b1;
    end else if (commit) begin
      disp_val     <= pending_val;
      pending_flag <= 1'b0;
      ready        <= 1'b1;
    end else if (load && ready) begin
      pending_val  <= value_in;
      pending_flag <= 1'b1;
      ready        <= 1'b0;
    end
  end

  assign cur_nibble = disp_val[4*int'(digit_idx) +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .hex (cur_nibble),
    .seg (seg_code)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= BLANK;
      an      <= '1;
      seg     <= SEG_OFF;
    end else begin
      state_q <= state_d;
      an      <= an_d;
      seg     <= seg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    an_d    = '1;
    seg_d   = SEG_OFF;
    if (state_q == BLANK && commit) begin
      state_d = SCAN;
    end
    for (int k = 0; k < DIGITS; k++) begin
      if (state_q == SCAN && digit_idx == IDX_W'(k) && !blank_mask[k]) begin
        an_d[k] = 1'b0;
      end
    end
    if (an_d != '1) begin
      seg_d = seg_code;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver; stimulus pushes expected display state, a monitor compares on request.
module tb_seg_scan_driver;

  logic        clk_in = 1'b0;
  logic        rst;
  logic        scan_clk;
  logic [15:0] value_in;
  logic        load;
  logic        ready;
  logic [3:0]  blank_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  typedef struct {
    string      name;
    logic [3:0] an;
    logic [6:0] seg;
    logic       ready;
  } exp_t;

  exp_t exp_q[$];
  logic chk_req = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [6:0] OFF = 7'h7F;

  seg_scan_driver #(.DIGITS(4), .SYNC_STAGES(2)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .scan_clk   (scan_clk),
    .value_in   (value_in),
    .load       (load),
    .ready      (ready),
    .blank_mask (blank_mask),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (chk_req) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: check requested with no expected entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (an !== e.an || seg !== e.seg || ready !== e.ready || dp !== 1'b1) begin
          n_fail++;
          $display("FAIL %s: got an=%b seg=%b ready=%b dp=%b, expected an=%b seg=%b ready=%b dp=1",
                   e.name, an, seg, ready, dp, e.an, e.seg, e.ready);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [3:0] a,
                            input logic [6:0] s, input logic r);
    exp_t e;
    e.name = name; e.an = a; e.seg = s; e.ready = r;
    exp_q.push_back(e);
    chk_req = 1'b1;
    @(negedge clk_in);
    #1;
    chk_req = 1'b0;
  endtask

  // One scan_clk rising edge; outputs reflect the new digit by the time this returns.
  task automatic scan_pulse();
    scan_clk = 1'b1;
    repeat (3) tick();
    scan_clk = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_load(input logic [15:0] v);
    value_in = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; scan_clk = 1'b0; value_in = '0; load = 1'b0; blank_mask = '0;
    // Reset while scan_clk toggles
    for (int i = 0; i < 8; i++) begin
      scan_clk = ~scan_clk;
      tick();
    end
    expect_out("reset_dark", 4'hF, OFF, 1'b1);
    scan_clk = 1'b0;
    tick();
    rst = 1'b0;
    repeat (2) tick();
    expect_out("after_reset", 4'hF, OFF, 1'b1);

    // First load, then an ignored second load
    do_load(16'h12AF);
    expect_out("ready_drop", 4'hF, OFF, 1'b0);
    do_load(16'h0000);
    expect_out("load_ignored", 4'hF, OFF, 1'b0);
    repeat (3) scan_pulse();
    expect_out("blank_before_wrap", 4'hF, OFF, 1'b0);
    scan_pulse();
    expect_out("commit_d0", 4'b1110, 7'b0001110, 1'b1);
    scan_pulse();
    expect_out("frame_d1", 4'b1101, 7'b0001000, 1'b1);
    scan_pulse();
    expect_out("frame_d2", 4'b1011, 7'b0100100, 1'b1);
    scan_pulse();
    expect_out("frame_d3", 4'b0111, 7'b1111001, 1'b1);

    // Load lands in the same cycle as the wrap step
    scan_clk = 1'b1;
    repeat (2) tick();
    value_in = 16'h0008;
    load = 1'b1;
    tick();
    load = 1'b0;
    scan_clk = 1'b0;
    repeat (3) tick();
    expect_out("wrap_load_d0_old", 4'b1110, 7'b0001110, 1'b0);
    repeat (3) scan_pulse();
    expect_out("wrap_load_d3_old", 4'b0111, 7'b1111001, 1'b0);
    scan_pulse();
    expect_out("wrap_load_commit", 4'b1110, 7'b0000000, 1'b1);

    // Live blank mask on digit 3
    blank_mask = 4'b1000;
    scan_pulse();
    expect_out("mask_d1", 4'b1101, 7'b1000000, 1'b1);
    scan_pulse();
    expect_out("mask_d2", 4'b1011, 7'b1000000, 1'b1);
    scan_pulse();
    expect_out("mask_d3_dark", 4'hF, OFF, 1'b1);
    scan_pulse();
    expect_out("mask_d0", 4'b1110, 7'b0000000, 1'b1);
    blank_mask = 4'b0000;

    // scan_clk toggling every cycle: five rising edges
    for (int i = 0; i < 5; i++) begin
      scan_clk = 1'b1;
      tick();
      scan_clk = 1'b0;
      tick();
    end
    repeat (4) tick();
    expect_out("fast_toggle_d1", 4'b1101, 7'b1000000, 1'b1);

    // scan_clk stuck high: only the one rising edge counts
    scan_clk = 1'b1;
    repeat (12) tick();
    expect_out("stuck_high_d2", 4'b1011, 7'b1000000, 1'b1);
    scan_clk = 1'b0;
    repeat (3) tick();

    // Reset mid-frame with a pending value
    do_load(16'h5555);
    expect_out("pre_reset_pending", 4'b1011, 7'b1000000, 1'b0);
    scan_pulse();
    expect_out("pre_reset_d3", 4'b0111, 7'b1000000, 1'b0);
    rst = 1'b1;
    repeat (2) tick();
    expect_out("mid_reset", 4'hF, OFF, 1'b1);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      scan_pulse();
      expect_out($sformatf("post_reset_dark%0d", i), 4'hF, OFF, 1'b1);
    end

    repeat (2) tick();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
